copperv_read_arbiter: RTL and testbench

//  Shares one memory read port between the core's instruction-read (ir) and data-read (dr) channels.

---
 rtl/copperv_arb_pkg.sv | 12 +
 rtl/copperv_tag_fifo.sv | 65 ++++++
 rtl/copperv_read_arbiter.sv | 134 +++++++++++++
 tb/tb_copperv_read_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/copperv_arb_pkg.sv
// Shared types for the copperv read arbiter: request source tag and stats width.
// Imported by copperv_tag_fifo and copperv_read_arbiter.
package copperv_arb_pkg;

    typedef enum logic {
        SRC_IR = 1'b0,
        SRC_DR = 1'b1
    } arb_src_t;

    localparam int ARB_STAT_WIDTH = 32;

endpackage

// File: rtl/copperv_tag_fifo.sv
// In-order FIFO of request source tags; head is read combinationally.
// Ports: clk, rst (async high), push/din, pop/dout, full, empty.
module copperv_tag_fifo
    import copperv_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  arb_src_t din,
    output arb_src_t dout,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    arb_src_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_cnt;

    logic w_push;
    logic w_pop;

    assign full   = (r_cnt == FULL_CNT);
    assign empty  = (r_cnt == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rd];

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= SRC_IR;
            end
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= din;
                r_wr        <= ptr_next(r_wr);
            end
            if (w_pop) begin
                r_rd <= ptr_next(r_rd);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/copperv_read_arbiter.sv
// Shares one memory read port between ir and dr: round-robin address grant,
// tag FIFO, and in-order routing of returned data beats to the issuing channel.
// Ports: ir_addr_*/ir_data_*, dr_addr_*/dr_data_* (core side), mem_addr_*/mem_data_*
// (memory side). COPPERV_RD_ARB_STATS_EN adds stat_ir_grants, stat_dr_grants,
// stat_stall_cycles counters.
module copperv_read_arbiter
    import copperv_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ir_addr_valid,
    output logic                  ir_addr_ready,
    input  logic [ADDR_WIDTH-1:0] ir_addr,
    output logic                  ir_data_valid,
    input  logic                  ir_data_ready,
    output logic [DATA_WIDTH-1:0] ir_data,
    input  logic                  dr_addr_valid,
    output logic                  dr_addr_ready,
    input  logic [ADDR_WIDTH-1:0] dr_addr,
    output logic                  dr_data_valid,
    input  logic                  dr_data_ready,
    output logic [DATA_WIDTH-1:0] dr_data,
    output logic                  mem_addr_valid,
    input  logic                  mem_addr_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_data_valid,
    output logic                  mem_data_ready,
    input  logic [DATA_WIDTH-1:0] mem_data
`ifdef COPPERV_RD_ARB_STATS_EN
    ,
    output logic [ARB_STAT_WIDTH-1:0] stat_ir_grants,
    output logic [ARB_STAT_WIDTH-1:0] stat_dr_grants,
    output logic [ARB_STAT_WIDTH-1:0] stat_stall_cycles
`endif
);

    logic     r_lock;
    arb_src_t r_grant;
    arb_src_t r_last;

    arb_src_t w_sel;
    logic     w_req;
    logic     w_xfer;
    logic     w_full;
    logic     w_empty;
    arb_src_t w_head;
    logic     w_head_ready;
    logic     w_pop;

    // A stalled request keeps its grant so the payload seen by memory
    // cannot change under it; otherwise the tie goes to whoever did not win last.
    always_comb begin
        w_sel = SRC_IR;
        if (r_lock) begin
            w_sel = r_grant;
        end else if (ir_addr_valid && dr_addr_valid) begin
            w_sel = (r_last == SRC_IR) ? SRC_DR : SRC_IR;
        end else if (dr_addr_valid) begin
            w_sel = SRC_DR;
        end
    end

    assign w_req          = (w_sel == SRC_IR) ? ir_addr_valid : dr_addr_valid;
    assign mem_addr_valid = w_req && !w_full;
    assign mem_addr       = (w_sel == SRC_IR) ? ir_addr : dr_addr;
    assign w_xfer         = mem_addr_valid && mem_addr_ready;
    assign ir_addr_ready  = w_xfer && (w_sel == SRC_IR);
    assign dr_addr_ready  = w_xfer && (w_sel == SRC_DR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock  <= 1'b0;
            r_grant <= SRC_IR;
            r_last  <= SRC_DR;
        end else if (w_xfer) begin
            r_lock <= 1'b0;
            r_last <= w_sel;
        end else if (mem_addr_valid) begin
            r_lock  <= 1'b1;
            r_grant <= w_sel;
        end
    end

    copperv_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tags (
        .clk   (clk),
        .rst   (rst),
        .push  (w_xfer),
        .pop   (w_pop),
        .din   (w_sel),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // With no tag queued a memory beat has no owner, so it is left pending.
    assign w_head_ready   = (w_head == SRC_IR) ? ir_data_ready : dr_data_ready;
    assign mem_data_ready = !w_empty && w_head_ready;
    assign ir_data_valid  = !w_empty && (w_head == SRC_IR) && mem_data_valid;
    assign dr_data_valid  = !w_empty && (w_head == SRC_DR) && mem_data_valid;
    assign ir_data        = mem_data;
    assign dr_data        = mem_data;
    assign w_pop          = mem_data_valid && mem_data_ready;

`ifdef COPPERV_RD_ARB_STATS_EN
    logic [ARB_STAT_WIDTH-1:0] r_stat_ir;
    logic [ARB_STAT_WIDTH-1:0] r_stat_dr;
    logic [ARB_STAT_WIDTH-1:0] r_stat_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_ir    <= '0;
            r_stat_dr    <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_xfer && (w_sel == SRC_IR)) r_stat_ir <= r_stat_ir + 1'b1;
            if (w_xfer && (w_sel == SRC_DR)) r_stat_dr <= r_stat_dr + 1'b1;
            if ((ir_addr_valid || dr_addr_valid) && !w_xfer) begin
                r_stat_stall <= r_stat_stall + 1'b1;
            end
        end
    end

    assign stat_ir_grants    = r_stat_ir;
    assign stat_dr_grants    = r_stat_dr;
    assign stat_stall_cycles = r_stat_stall;
`endif

endmodule

// File: tb/tb_copperv_read_arbiter.sv
// Scoreboard bench for copperv_read_arbiter: directed stimulus pushes expected
// addresses/data; a negedge monitor pops and compares on every handshake.
module tb_copperv_read_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ir_addr_valid, ir_addr_ready;
    logic [31:0] ir_addr;
    logic        ir_data_valid, ir_data_ready;
    logic [31:0] ir_data;
    logic        dr_addr_valid, dr_addr_ready;
    logic [31:0] dr_addr;
    logic        dr_data_valid, dr_data_ready;
    logic [31:0] dr_data;
    logic        mem_addr_valid, mem_addr_ready;
    logic [31:0] mem_addr;
    logic        mem_data_valid, mem_data_ready;
    logic [31:0] mem_data;
`ifdef COPPERV_RD_ARB_STATS_EN
    logic [31:0] stat_ir_grants, stat_dr_grants, stat_stall_cycles;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] q_addr [$];
    logic [31:0] q_ir   [$];
    logic [31:0] q_dr   [$];

    always #5 clk = ~clk;

    copperv_read_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .ir_addr_valid  (ir_addr_valid),
        .ir_addr_ready  (ir_addr_ready),
        .ir_addr        (ir_addr),
        .ir_data_valid  (ir_data_valid),
        .ir_data_ready  (ir_data_ready),
        .ir_data        (ir_data),
        .dr_addr_valid  (dr_addr_valid),
        .dr_addr_ready  (dr_addr_ready),
        .dr_addr        (dr_addr),
        .dr_data_valid  (dr_data_valid),
        .dr_data_ready  (dr_data_ready),
        .dr_data        (dr_data),
        .mem_addr_valid (mem_addr_valid),
        .mem_addr_ready (mem_addr_ready),
        .mem_addr       (mem_addr),
        .mem_data_valid (mem_data_valid),
        .mem_data_ready (mem_data_ready),
        .mem_data       (mem_data)
`ifdef COPPERV_RD_ARB_STATS_EN
        ,
        .stat_ir_grants    (stat_ir_grants),
        .stat_dr_grants    (stat_dr_grants),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Monitor: every handshake must match the head of its expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_addr_valid && mem_addr_ready) begin
                if (q_addr.size() == 0) chk("mem_addr_unexpected", mem_addr, 32'hxxxx_xxxx);
                else chk("mem_addr", mem_addr, q_addr.pop_front());
            end
            if (ir_data_valid && ir_data_ready) begin
                if (q_ir.size() == 0) chk("ir_data_unexpected", ir_data, 32'hxxxx_xxxx);
                else chk("ir_data", ir_data, q_ir.pop_front());
            end
            if (dr_data_valid && dr_data_ready) begin
                if (q_dr.size() == 0) chk("dr_data_unexpected", dr_data, 32'hxxxx_xxxx);
                else chk("dr_data", dr_data, q_dr.pop_front());
            end
        end
    end

    task automatic chk_idle(input string nm);
        chk({nm, "_mav"}, 32'(mem_addr_valid), 0);
        chk({nm, "_mdr"}, 32'(mem_data_ready), 0);
        chk({nm, "_iar"}, 32'(ir_addr_ready), 0);
        chk({nm, "_dar"}, 32'(dr_addr_ready), 0);
        chk({nm, "_idv"}, 32'(ir_data_valid), 0);
        chk({nm, "_ddv"}, 32'(dr_data_valid), 0);
    endtask

    initial begin
        rst = 1'b1;
        ir_addr_valid = 0; ir_addr = 0; ir_data_ready = 0;
        dr_addr_valid = 0; dr_addr = 0; dr_data_ready = 0;
        mem_addr_ready = 0; mem_data_valid = 0; mem_data = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // 1: queue dr then ir tags, reset mid-burst
        mem_addr_ready = 1;
        dr_addr_valid = 1; dr_addr = 32'h80; q_addr.push_back(32'h80);
        tick();
        dr_addr_valid = 0;
        ir_addr_valid = 1; ir_addr = 32'h40; q_addr.push_back(32'h40);
        tick();
        ir_addr_valid = 0;
        mem_data_valid = 1; mem_data = 32'hDEAD;
        settle();
        chk("pre_reset_head_dr", 32'(dr_data_valid), 1);
        rst = 1'b1;
        #1;
        chk_idle("in_reset");
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk_idle("after_reset");
        tick();
        mem_data_valid = 0;

        // 2: tie, ir first after reset, alternating
        ir_addr_valid = 1; ir_addr = 32'h100;
        dr_addr_valid = 1; dr_addr = 32'h2000;
        q_addr.push_back(32'h100); q_addr.push_back(32'h2000);
        q_addr.push_back(32'h100); q_addr.push_back(32'h2000);
        settle();
        chk("tie_first_ir", mem_addr, 32'h100);
        tick();
        repeat (3) tick();
        ir_addr_valid = 0; dr_addr_valid = 0;
`ifdef COPPERV_RD_ARB_STATS_EN
        settle();
        chk("stat_ir", stat_ir_grants, 2);
        chk("stat_dr", stat_dr_grants, 2);
        chk("stat_stall", stat_stall_cycles, 0);
        tick();
`endif
        ir_data_ready = 1; dr_data_ready = 1; mem_data_valid = 1;
        q_ir.push_back(32'h11); q_dr.push_back(32'h22);
        q_ir.push_back(32'h33); q_dr.push_back(32'h44);
        mem_data = 32'h11; tick();
        mem_data = 32'h22; tick();
        mem_data = 32'h33; tick();
        mem_data = 32'h44; tick();
        mem_data_valid = 0;

        // 3: dr locked while memory stalls, ir waits
        mem_addr_ready = 0;
        dr_addr_valid = 1; dr_addr = 32'h2000;
        q_addr.push_back(32'h2000); q_addr.push_back(32'h300);
        tick();
        ir_addr_valid = 1; ir_addr = 32'h300;
        settle();
        chk("lock_addr", mem_addr, 32'h2000);
        chk("lock_mav", 32'(mem_addr_valid), 1);
        chk("lock_iar", 32'(ir_addr_ready), 0);
        tick();
        tick();
        mem_addr_ready = 1;
        settle();
        chk("lock_release_addr", mem_addr, 32'h2000);
        chk("lock_release_dar", 32'(dr_addr_ready), 1);
        tick();
        dr_addr_valid = 0;
        settle();
        chk("after_lock_addr", mem_addr, 32'h300);
        chk("after_lock_iar", 32'(ir_addr_ready), 1);
        tick();
        ir_addr_valid = 0;
        mem_data_valid = 1;
        q_dr.push_back(32'h55); q_ir.push_back(32'h66);
        mem_data = 32'h55; tick();
        mem_data = 32'h66; tick();
        mem_data_valid = 0;

        // 4: fill tag FIFO with ir, dr blocked until one pop
        ir_addr_valid = 1;
        for (int i = 0; i < 4; i++) begin
            ir_addr = 32'h400 + 32'(i * 4);
            q_addr.push_back(ir_addr);
            tick();
        end
        ir_addr_valid = 0;
        dr_addr_valid = 1; dr_addr = 32'h500; q_addr.push_back(32'h500);
        settle();
        chk("full_mav", 32'(mem_addr_valid), 0);
        chk("full_dar", 32'(dr_addr_ready), 0);
        tick();
        mem_data_valid = 1; mem_data = 32'h77; q_ir.push_back(32'h77);
        settle();
        chk("full_pop_mdr", 32'(mem_data_ready), 1);
        chk("full_pop_mav", 32'(mem_addr_valid), 0);
        tick();
        mem_data_valid = 0;
        settle();
        chk("after_pop_mav", 32'(mem_addr_valid), 1);
        chk("after_pop_addr", mem_addr, 32'h500);
        tick();
        dr_addr_valid = 0;
        mem_data_valid = 1;
        q_ir.push_back(32'h78); q_ir.push_back(32'h79);
        q_ir.push_back(32'h7A); q_dr.push_back(32'h7B);
        mem_data = 32'h78; tick();
        mem_data = 32'h79; tick();
        mem_data = 32'h7A; tick();
        mem_data = 32'h7B; tick();
        mem_data_valid = 0;

        // 5: routing ir,dr,ir with dr backpressure
        ir_addr_valid = 1; ir_addr = 32'h600; q_addr.push_back(32'h600);
        tick();
        ir_addr_valid = 0;
        dr_addr_valid = 1; dr_addr = 32'h700; q_addr.push_back(32'h700);
        tick();
        dr_addr_valid = 0;
        ir_addr_valid = 1; ir_addr = 32'h800; q_addr.push_back(32'h800);
        tick();
        ir_addr_valid = 0;
        q_ir.push_back(32'hA); q_dr.push_back(32'hB); q_ir.push_back(32'hC);
        dr_data_ready = 0; ir_data_ready = 1;
        mem_data_valid = 1; mem_data = 32'hA;
        tick();
        mem_data = 32'hB;
        settle();
        chk("hold_ddv", 32'(dr_data_valid), 1);
        chk("hold_dd", dr_data, 32'hB);
        chk("hold_mdr", 32'(mem_data_ready), 0);
        chk("hold_idv", 32'(ir_data_valid), 0);
        tick();
        settle();
        chk("hold2_ddv", 32'(dr_data_valid), 1);
        tick();
        dr_data_ready = 1;
        tick();
        mem_data = 32'hC;
        tick();
        mem_data_valid = 0;
        settle();
        chk_idle("drained");
        tick();

        chk("q_addr_left", 32'(q_addr.size()), 0);
        chk("q_ir_left", 32'(q_ir.size()), 0);
        chk("q_dr_left", 32'(q_dr.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
